// File: rtl/mat_cache_seq_pkg.sv
// Shared types for the MatCache block sequencer and its cache port mux.
package mat_cache_seq_pkg;

    // Cache elements are carried as raw shortreal bit patterns.
    localparam int unsigned MAT_ELEM_W = 32;

    typedef enum logic [1:0] {
        MAT_SEQ_COPY  = 2'd0,
        MAT_SEQ_XPOSE = 2'd1,
        MAT_SEQ_DIAG  = 2'd2
    } MatSeqOp_t;

    typedef enum logic [1:0] {
        MAT_DATA_READ_NONE = 2'd0,
        MAT_DATA_READ_ROW  = 2'd1,
        MAT_DATA_READ_COL  = 2'd2,
        MAT_DATA_READ_DIAG = 2'd3
    } MatDataReadOp_t;

    typedef enum logic [1:0] {
        MAT_DATA_WRITE_NONE = 2'd0,
        MAT_DATA_WRITE_ROW  = 2'd1,
        MAT_DATA_WRITE_COL  = 2'd2
    } MatDataWriteOp_t;

    function automatic MatDataReadOp_t seq_read_op_of(input MatSeqOp_t op);
        return (op == MAT_SEQ_DIAG) ? MAT_DATA_READ_DIAG : MAT_DATA_READ_ROW;
    endfunction

    function automatic MatDataWriteOp_t seq_write_op_of(input MatSeqOp_t op);
        return (op == MAT_SEQ_XPOSE) ? MAT_DATA_WRITE_COL : MAT_DATA_WRITE_ROW;
    endfunction

endpackage

// File: rtl/mat_cache_port_mux.sv
// Selects whether the host port or the sequencer drives the MatCache read/write ports.
module mat_cache_port_mux
    import mat_cache_seq_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned CACHE_SIZE = 4,
    localparam int unsigned AW = $clog2(CACHE_SIZE),
    localparam int unsigned PW = $clog2(WIDTH)
) (
    input  logic                             seq_sel,
    input  MatDataReadOp_t                   host_read_op,
    input  logic [AW-1:0]                    host_read_addr1,
    input  logic [AW-1:0]                    host_read_addr2,
    input  logic [PW-1:0]                    host_read_param,
    input  MatDataWriteOp_t                  host_write_op,
    input  logic [AW-1:0]                    host_write_addr1,
    input  logic [PW-1:0]                    host_write_param1,
    input  logic [PW-1:0]                    host_write_param2,
    input  logic [WIDTH-1:0][MAT_ELEM_W-1:0] host_data_in,
    output logic [WIDTH-1:0][MAT_ELEM_W-1:0] host_data_out,
    input  MatDataReadOp_t                   seq_read_op,
    input  logic [AW-1:0]                    seq_read_addr1,
    input  logic [AW-1:0]                    seq_read_addr2,
    input  logic [PW-1:0]                    seq_read_param,
    input  MatDataWriteOp_t                  seq_write_op,
    input  logic [AW-1:0]                    seq_write_addr1,
    input  logic [PW-1:0]                    seq_write_param1,
    input  logic [PW-1:0]                    seq_write_param2,
    input  logic [WIDTH-1:0][MAT_ELEM_W-1:0] seq_data_in,
    output MatDataReadOp_t                   read_op,
    output logic [AW-1:0]                    read_addr1,
    output logic [AW-1:0]                    read_addr2,
    output logic [PW-1:0]                    read_param,
    output MatDataWriteOp_t                  write_op,
    output logic [AW-1:0]                    write_addr1,
    output logic [PW-1:0]                    write_param1,
    output logic [PW-1:0]                    write_param2,
    output logic [WIDTH-1:0][MAT_ELEM_W-1:0] cache_data_in,
    input  logic [WIDTH-1:0][MAT_ELEM_W-1:0] cache_data_out
);

    always_comb begin
        if (seq_sel) begin
            read_op       = seq_read_op;
            read_addr1    = seq_read_addr1;
            read_addr2    = seq_read_addr2;
            read_param    = seq_read_param;
            write_op      = seq_write_op;
            write_addr1   = seq_write_addr1;
            write_param1  = seq_write_param1;
            write_param2  = seq_write_param2;
            cache_data_in = seq_data_in;
        end else begin
            read_op       = host_read_op;
            read_addr1    = host_read_addr1;
            read_addr2    = host_read_addr2;
            read_param    = host_read_param;
            write_op      = host_write_op;
            write_addr1   = host_write_addr1;
            write_param1  = host_write_param1;
            write_param2  = host_write_param2;
            cache_data_in = host_data_in;
        end
    end

    assign host_data_out = cache_data_out;

endmodule

// File: rtl/mat_cache_seq.sv
// Block-command sequencer and host/sequencer arbiter in front of MatCache.
// Define MAT_SEQ_PERF_CNT_EN to add the perf_cmds / perf_busy_cycles counters.
module mat_cache_seq
    import mat_cache_seq_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned CACHE_SIZE = 4,
    localparam int unsigned AW = $clog2(CACHE_SIZE),
    localparam int unsigned PW = $clog2(WIDTH)
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  MatSeqOp_t                        cmd_op,
    input  logic [AW-1:0]                    cmd_src,
    input  logic [AW-1:0]                    cmd_dst,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
`ifdef MAT_SEQ_PERF_CNT_EN
    output logic [31:0]                      perf_cmds,
    output logic [31:0]                      perf_busy_cycles,
`endif
    input  MatDataReadOp_t                   host_read_op,
    input  logic [AW-1:0]                    host_read_addr1,
    input  logic [AW-1:0]                    host_read_addr2,
    input  logic [PW-1:0]                    host_read_param,
    input  MatDataWriteOp_t                  host_write_op,
    input  logic [AW-1:0]                    host_write_addr1,
    input  logic [PW-1:0]                    host_write_param1,
    input  logic [PW-1:0]                    host_write_param2,
    input  logic [WIDTH-1:0][MAT_ELEM_W-1:0] host_data_in,
    output logic [WIDTH-1:0][MAT_ELEM_W-1:0] host_data_out,
    output logic                             host_grant,
    output MatDataReadOp_t                   read_op,
    output logic [AW-1:0]                    read_addr1,
    output logic [AW-1:0]                    read_addr2,
    output logic [PW-1:0]                    read_param,
    output MatDataWriteOp_t                  write_op,
    output logic [AW-1:0]                    write_addr1,
    output logic [PW-1:0]                    write_param1,
    output logic [PW-1:0]                    write_param2,
    output logic [WIDTH-1:0][MAT_ELEM_W-1:0] cache_data_in,
    input  logic [WIDTH-1:0][MAT_ELEM_W-1:0] cache_data_out
);

    typedef logic [1:0] MatSeqState_t;

    localparam MatSeqState_t ST_IDLE = 2'd0;
    localparam MatSeqState_t ST_RUN  = 2'd1;
    localparam MatSeqState_t ST_DONE = 2'd2;

    localparam logic [PW-1:0] LAST_STEP = PW'(WIDTH - 1);

    MatSeqState_t    state_q, state_d;
    logic [PW-1:0]   step_q, step_d;
    MatSeqOp_t       op_q, op_d;
    logic [AW-1:0]   src_q, src_d;
    logic [AW-1:0]   dst_q, dst_d;
    logic            err_q, err_d;
    logic            accept;

    MatDataReadOp_t  seq_read_op;
    MatDataWriteOp_t seq_write_op;

    assign cmd_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign host_grant = ~busy;
    assign done       = (state_q == ST_DONE);
    assign err        = (state_q == ST_DONE) && err_q;
    assign accept     = cmd_valid && cmd_ready;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        op_d    = op_q;
        src_d   = src_q;
        dst_d   = dst_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d   = cmd_op;
                    src_d  = cmd_src;
                    dst_d  = cmd_dst;
                    step_d = '0;
                    // An in-place transpose would clobber unread columns; reject it.
                    if (cmd_op == MAT_SEQ_XPOSE && cmd_src == cmd_dst) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (step_q == LAST_STEP) begin
                    state_d = ST_DONE;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            op_q    <= MAT_SEQ_COPY;
            src_q   <= '0;
            dst_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            op_q    <= op_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            err_q   <= err_d;
        end
    end

    // Outside RUN the sequencer side is quiet, so DONE issues no writes.
    assign seq_read_op  = (state_q == ST_RUN) ? seq_read_op_of(op_q) : MAT_DATA_READ_NONE;
    assign seq_write_op = (state_q == ST_RUN) ? seq_write_op_of(op_q) : MAT_DATA_WRITE_NONE;

    mat_cache_port_mux #(
        .WIDTH      (WIDTH),
        .CACHE_SIZE (CACHE_SIZE)
    ) u_port_mux (
        .seq_sel           (busy),
        .host_read_op      (host_read_op),
        .host_read_addr1   (host_read_addr1),
        .host_read_addr2   (host_read_addr2),
        .host_read_param   (host_read_param),
        .host_write_op     (host_write_op),
        .host_write_addr1  (host_write_addr1),
        .host_write_param1 (host_write_param1),
        .host_write_param2 (host_write_param2),
        .host_data_in      (host_data_in),
        .host_data_out     (host_data_out),
        .seq_read_op       (seq_read_op),
        .seq_read_addr1    (src_q),
        .seq_read_addr2    (src_q),
        .seq_read_param    (step_q),
        .seq_write_op      (seq_write_op),
        .seq_write_addr1   (dst_q),
        .seq_write_param1  (step_q),
        .seq_write_param2  ({PW{1'b0}}),
        .seq_data_in       (cache_data_out),
        .read_op           (read_op),
        .read_addr1        (read_addr1),
        .read_addr2        (read_addr2),
        .read_param        (read_param),
        .write_op          (write_op),
        .write_addr1       (write_addr1),
        .write_param1      (write_param1),
        .write_param2      (write_param2),
        .cache_data_in     (cache_data_in),
        .cache_data_out    (cache_data_out)
    );

`ifdef MAT_SEQ_PERF_CNT_EN
    logic [31:0] perf_cmds_q;
    logic [31:0] perf_busy_cycles_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_cmds_q        <= '0;
            perf_busy_cycles_q <= '0;
        end else begin
            if (state_q == ST_DONE) begin
                perf_cmds_q <= perf_cmds_q + 32'd1;
            end
            if (busy) begin
                perf_busy_cycles_q <= perf_busy_cycles_q + 32'd1;
            end
        end
    end

    assign perf_cmds        = perf_cmds_q;
    assign perf_busy_cycles = perf_busy_cycles_q;
`endif

endmodule
